// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_e               : FSM encoding (IDLE/SHIFT/DONE; 2'b11 unused, recovers to IDLE)
//   SERIAL_SUB_WIDTH_DEF  : default operand width
package serial_sub_pkg;
  localparam int SERIAL_SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;
endpackage

// File: rtl/full_sub_bit.sv
// full_sub_bit: 1-bit full subtractor, x - y - bin.
//   x, y  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
// Built as two cascaded half-subtractors whose borrows are ORed
// (both can never be set at once, so OR is sufficient).
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  // half stage 1: x - y
  assign d1 = x ^ y;
  assign b1 = ~x & y;
  // half stage 2: d1 - bin
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one bit per clock.
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled only in IDLE
//   a, b       : minuend / subtrahend, captured on accepted start
//   busy       : high in SHIFT and DONE
//   done       : one-cycle pulse, result valid
//   diff       : a - b mod 2^WIDTH (partial during SHIFT)
//   borrow     : 1 iff a < b unsigned
//   ovf        : signed overflow, only when SERIAL_SUB_OVF_EN is defined
// Optional feature macro: SERIAL_SUB_OVF_EN
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             d_bit, bout;

  full_sub_bit u_fsb (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (bin_q),
    .d    (d_bit),
    .bout (bout)
  );

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d  = am_q;
    bm_d  = bm_q;
    ovf_d = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          am_d  = a[WIDTH-1];
          bm_d  = b[WIDTH-1];
          ovf_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        bin_d  = bout;
        cnt_d  = cnt_q + CW'(1);
        // last bit: d_bit is the result MSB, bout the final borrow
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          borrow_d = bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d = (am_q != bm_q) && (d_bit != am_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == SHIFT) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf = ovf_q;
`endif
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing A − B LSB-first, one bit per clock, through a single 1-bit full-subtract cell built from two half-subtractor stages plus a registered borrow. It sits directly downstream of the combinational half-subtractor cell: it consumes that cell's borrow/difference outputs each cycle and turns them into a multi-bit result with a start/done handshake. It is the sequential datapath stage for the lab's multi-bit subtraction.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2–32.
- clk  input  1  rising-edge clock; the block has one clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result is valid.
- diff  output  WIDTH  difference, a − b mod 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff a < b unsigned.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Load a/b shift registers.
  - Clear the borrow flop and the bit counter.
  - Go to SHIFT.
- IDLE, start=0: hold all outputs.
- SHIFT, each cycle (x = a_sr[0], y = b_sr[0], bin = borrow flop):
  - Half stage 1: d1 = x^y, b1 = ~x&y.
  - Half stage 2: d = d1^bin, b2 = ~d1&bin.
  - bout = b1|b2.
  - Shift d into diff MSB, with diff shifting right.
  - Shift a_sr and b_sr right.
  - Borrow flop <= bout; counter++.
- SHIFT, after the WIDTH-th shift:
  - Go to DONE.
  - borrow output <= final bout.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- diff and borrow hold their values after DONE until the next accepted start.
- start while busy=1 (SHIFT or DONE) is ignored; it is not queued.
- diff contents during SHIFT are partial and not valid.
- Counter width is $clog2(WIDTH)+1. The terminal compare is count == WIDTH-1 at the shift cycle.

## Timing
- Reset values: state IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0; counter, shift registers and borrow flop all 0.
- Reset is asynchronous and overrides everything. Asserting it mid-SHIFT aborts the operation immediately, and the block returns to IDLE with reset values.
- Cycle-level sequence:
  - Edge E0: start accepted; busy=1 after E0.
  - Edges E1…E_WIDTH: shifts; state=DONE after E_WIDTH.
  - done=1 between E_WIDTH and E_WIDTH+1.
  - Back in IDLE after E_WIDTH+1, so busy=0 there.
- Latency from start accepted to done high is WIDTH+1 edges. Minimum start-to-start throughput is WIDTH+2 cycles.
- start can be accepted again in the first IDLE cycle after DONE.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - ovf port exists.
  - Capture a[WIDTH-1] and b[WIDTH-1] into dedicated flops at start.
  - On entry to DONE, ovf <= (a_msb != b_msb) && (d_last != a_msb), where d_last is the final difference bit.
  - ovf holds until the next accepted start and clears to 0 at start.
- SERIAL_SUB_OVF_EN undefined: no ovf port and no MSB capture flops. Everything else is identical.

## Structure
- Package serial_sub_pkg:
  - State encoding typedef: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10; the 2'b11 encoding recovers to IDLE.
  - Default-width constant SERIAL_SUB_WIDTH_DEF = 8.
- One sub-module, full_sub_bit:
  - Ports x, y, bin → d, bout.
  - Internally composed of two half-subtract stages and an OR gate.
  - The top level instantiates it once.

## Test plan
- a=0x5A, b=0x3C, start → done after 9 edges; diff=0x1E, borrow=0, ovf=0.
- a=0x03, b=0x05 → diff=0xFE, borrow=1, ovf=0.
- a=0x80, b=0x01 → diff=0x7F, borrow=0, ovf=1 (with macro); a=0x7F, b=0xFF → diff=0x80, borrow=1, ovf=1.
- a=0x00, b=0x00 → diff=0x00, borrow=0; done is high exactly one cycle and busy drops the next cycle.
- Start again at cycle 3 of SHIFT with a=0xFF, b=0x00 → ignored; the original result is delivered with unchanged timing.
- rst_n low at cycle 4 of SHIFT → all outputs 0 immediately. After release, a new start with a=0x10, b=0x01 gives diff=0x0F, borrow=0.
